morph_stream: RTL and testbench

// - Streaming binary morphology filter, parametrised successor of the fixed 3x3 erode/dilate stage.
// - Accepts one pixel per clock in raster order and emits one filtered pixel per clock, in raster order.
// - Selectable operation: erode, dilate, majority or bypass.
// - Explicit frame bookkeeping: border substitution, end-of-frame flush, and sof/eof flags for the downstream frame store.
// - Sits between the binarised pixel source and the output cache/address generator.

---
 rtl/morph_pkg.sv | 39 +++
 rtl/morph_window.sv | 45 ++++
 rtl/morph_stream.sv | 170 +++++++++++++++++
 tb/tb_morph_stream.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morph_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | morph_pkg : shared types and tap-reduction helpers for morph_stream |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
package morph_pkg;

  typedef enum logic [1:0] {
    MODE_ERODE  = 2'd0,
    MODE_DILATE = 2'd1,
    MODE_MAJ    = 2'd2,
    MODE_BYPASS = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // Largest window (7x7) the helpers have to cover.
  localparam int c_TAPS_MAX = 49;

  function automatic logic [5:0] popcount(input logic [c_TAPS_MAX-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < c_TAPS_MAX; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

  function automatic int maj_threshold(input int k);
    return (k * k) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/morph_window.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | morph_window : K-1 line buffers plus KxK window over a pixel stream |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
module morph_window #(
  parameter int IMG_W = 256,
  parameter int K     = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_shift,
  input  logic           i_din,
  output logic [K*K-1:0] o_window
);

  // Tap (r,c) is the sample (K-1-r) rows and (K-1-c) columns older than the
  // newest one; rows above the bottom are served from the line buffers.
  localparam int c_LEN = (K - 1) * IMG_W + K - 1;

  logic [c_LEN-1:0] r_hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '0;
    end else if (i_shift) begin
      r_hist <= {r_hist[c_LEN-2:0], i_din};
    end
  end

  // The bus shows the window as it stands after this cycle's shift, so the
  // filtered result can be registered on the same edge as the accept.
  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      localparam int c_DLY = (K - 1 - r) * IMG_W + (K - 1 - c);
      if (c_DLY == 0) begin : g_live
        assign o_window[r*K+c] = i_din;
      end else begin : g_hist
        assign o_window[r*K+c] = r_hist[c_DLY-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/morph_stream.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | morph_stream : streaming binary erode/dilate/majority/bypass filter |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
module morph_stream
  import morph_pkg::*;
#(
  parameter int   IMG_W      = 256,
  parameter int   IMG_H      = 128,
  parameter int   K          = 3,
  parameter logic BORDER_VAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_mode,
  input  logic       i_in_valid,
  input  logic       i_in_pixel,
  output logic       o_in_ready,
  output logic       o_out_valid,
  output logic       o_out_pixel,
  output logic       o_out_sof,
  output logic       o_out_eof,
  output logic       o_busy
);

  localparam int R  = K / 2;
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW = $clog2(K * K + 1);

  localparam logic [XW-1:0] c_X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] c_Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] c_X_R    = XW'(R);
  localparam logic [YW-1:0] c_Y_R    = YW'(R);
  localparam logic [XW-1:0] c_X_ONE  = XW'(1);
  localparam logic [YW-1:0] c_Y_ONE  = YW'(1);

  state_t        r_state;
  mode_t         r_mode_q;
  logic [XW-1:0] r_in_x, r_out_x;
  logic [YW-1:0] r_in_y, r_out_y;
  logic          r_in_ready, r_out_valid, r_out_pixel, r_out_sof, r_out_eof, r_busy;

  logic                  w_accept, w_inject, w_shift, w_din, w_emit;
  logic                  w_in_last, w_fill_done, w_out_first, w_out_last, w_result;
  logic [K*K-1:0]        w_window, w_taps;
  logic [c_TAPS_MAX-1:0] w_taps_ext;
  logic [CW-1:0]         w_count;

  assign w_accept    = i_in_valid && r_in_ready;
  assign w_inject    = (r_state == FLUSH);
  assign w_shift     = w_accept || w_inject;
  assign w_din       = w_inject ? BORDER_VAL : i_in_pixel;
  assign w_in_last   = (r_in_x == c_X_LAST) && (r_in_y == c_Y_LAST);
  assign w_fill_done = (r_in_x == c_X_R) && (r_in_y == c_Y_R);
  assign w_out_first = (r_out_x == '0) && (r_out_y == '0);
  assign w_out_last  = (r_out_x == c_X_LAST) && (r_out_y == c_Y_LAST);
  assign w_emit      = w_inject ||
                       (w_accept && ((r_state == RUN) || ((r_state == FILL) && w_fill_done)));

  morph_window #(
    .IMG_W (IMG_W),
    .K     (K)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .i_shift  (w_shift),
    .i_din    (w_din),
    .o_window (w_window)
  );

  // Taps falling outside the frame around the current output pixel read the
  // border value; this also hides wrapped rows and the previous frame.
  always_comb begin
    w_taps = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        if ((int'(r_out_x) + c - R >= 0) && (int'(r_out_x) + c - R < IMG_W) &&
            (int'(r_out_y) + r - R >= 0) && (int'(r_out_y) + r - R < IMG_H)) begin
          w_taps[r*K+c] = w_window[r*K+c];
        end else begin
          w_taps[r*K+c] = BORDER_VAL;
        end
      end
    end
  end

  always_comb begin
    w_taps_ext              = '0;
    w_taps_ext[K*K-1:0]     = w_taps;
    w_count                 = CW'(popcount(w_taps_ext));
    w_result                = 1'b0;
    case (r_mode_q)
      MODE_ERODE:  w_result = &w_taps;
      MODE_DILATE: w_result = |w_taps;
      MODE_MAJ:    w_result = (w_count > CW'(maj_threshold(K)));
      default:     w_result = w_taps[R*K+R];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mode_q    <= MODE_ERODE;
      r_in_x      <= '0;
      r_in_y      <= '0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_pixel <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eof   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_out_valid <= w_emit;
      r_out_pixel <= w_emit && w_result;
      r_out_sof   <= w_emit && w_out_first;
      r_out_eof   <= w_emit && w_out_last;

      if (w_emit) begin
        if (r_out_x == c_X_LAST) begin
          r_out_x <= '0;
          r_out_y <= (r_out_y == c_Y_LAST) ? '0 : r_out_y + c_Y_ONE;
        end else begin
          r_out_x <= r_out_x + c_X_ONE;
        end
      end

      if (w_accept) begin
        if (r_in_x == c_X_LAST) begin
          r_in_x <= '0;
          r_in_y <= (r_in_y == c_Y_LAST) ? '0 : r_in_y + c_Y_ONE;
        end else begin
          r_in_x <= r_in_x + c_X_ONE;
        end
      end

      case (r_state)
        IDLE: if (w_accept) begin
          r_mode_q <= mode_t'(i_mode);
          r_busy   <= 1'b1;
          r_state  <= FILL;
        end
        FILL: if (w_accept && w_fill_done) begin
          r_state <= RUN;
        end
        RUN: if (w_accept && w_in_last) begin
          r_in_ready <= 1'b0;
          r_state    <= FLUSH;
        end
        FLUSH: if (w_out_last) begin
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_pixel = r_out_pixel;
  assign o_out_sof   = r_out_sof;
  assign o_out_eof   = r_out_eof;
  assign o_busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_morph_stream.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_morph_stream : scoreboard bench, 8x6/K3 and 16x8/K5 instances    |
// | Revision        : 1.0                                               |
// +--------------------------------------------------------------------+
module tb_morph_stream;

  localparam int W0 = 8,  H0 = 6, K0 = 3;
  localparam int W1 = 16, H1 = 8, K1 = 5;

  logic clk = 1'b0;
  logic rst0, rst1;
  logic [1:0] mode0, mode1;
  logic vld0, px0, vld1, px1;
  logic rdy0, ov0, op0, sof0, eof0, busy0;
  logic rdy1, ov1, op1, sof1, eof1, busy1;

  int checks = 0;
  int errors = 0;
  logic [2:0] q0[$];
  logic [2:0] q1[$];
  logic [2:0] got0, exp0, got1, exp1;
  bit   pat[128];
  int   out_cnt[2]  = '{0, 0};
  int   ones_cnt[2] = '{0, 0};
  time  acc_t[128];
  time  sof_t0;
  int   lo_cnt0 = 0;

  always #5 clk = ~clk;

  morph_stream #(.IMG_W(W0), .IMG_H(H0), .K(K0), .BORDER_VAL(1'b0)) u_dut0 (
    .clk(clk), .rst(rst0), .i_mode(mode0), .i_in_valid(vld0), .i_in_pixel(px0),
    .o_in_ready(rdy0), .o_out_valid(ov0), .o_out_pixel(op0), .o_out_sof(sof0),
    .o_out_eof(eof0), .o_busy(busy0));

  morph_stream #(.IMG_W(W1), .IMG_H(H1), .K(K1), .BORDER_VAL(1'b0)) u_dut1 (
    .clk(clk), .rst(rst1), .i_mode(mode1), .i_in_valid(vld1), .i_in_pixel(px1),
    .o_in_ready(rdy1), .o_out_valid(ov1), .o_out_pixel(op1), .o_out_sof(sof1),
    .o_out_eof(eof1), .o_busy(busy1));

  // Monitors: pop the scoreboard whenever an output is presented.
  always @(negedge clk) begin
    if (!rst0) begin
      if (!rdy0) lo_cnt0++;
      if (ov0) begin
        got0 = {op0, sof0, eof0};
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL out0_extra got={pix,sof,eof}=%b expected none", got0);
        end else begin
          exp0 = q0.pop_front();
          if (got0 !== exp0) begin
            errors++;
            $display("FAIL out0_pixel n=%0d got={pix,sof,eof}=%b expected=%b", out_cnt[0], got0, exp0);
          end
        end
        if (sof0) sof_t0 = $time;
        out_cnt[0]++;
        ones_cnt[0] += int'(op0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst1 && ov1) begin
      got1 = {op1, sof1, eof1};
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL out1_extra got={pix,sof,eof}=%b expected none", got1);
      end else begin
        exp1 = q1.pop_front();
        if (got1 !== exp1) begin
          errors++;
          $display("FAIL out1_pixel n=%0d got={pix,sof,eof}=%b expected=%b", out_cnt[1], got1, exp1);
        end
      end
      out_cnt[1]++;
      ones_cnt[1] += int'(op1);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  function automatic logic get_rdy(input int d);
    return (d == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic get_busy(input int d);
    return (d == 0) ? busy0 : busy1;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic set_in(input int d, input logic v, input logic p);
    if (d == 0) begin vld0 = v; px0 = p; end
    else        begin vld1 = v; px1 = p; end
  endtask

  task automatic check_idle_outputs(input int d, input string name);
    logic [5:0] v;
    v = (d == 0) ? {rdy0, ov0, op0, sof0, eof0, busy0} : {rdy1, ov1, op1, sof1, eof1, busy1};
    checks++;
    if (v !== 6'b100000) begin
      errors++;
      $display("FAIL %s got={rdy,vld,pix,sof,eof,busy}=%b expected=100000", name, v);
    end
  endtask

  // kind: 0 all ones, 1 single pixel at (3,2), 2 checkerboard, 3 random
  task automatic gen_pat(input int w, input int h, input int kind, input int dens);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        case (kind)
          0:       pat[y*w+x] = 1'b1;
          1:       pat[y*w+x] = (x == 3 && y == 2);
          2:       pat[y*w+x] = ((x + y) % 2 == 0);
          default: pat[y*w+x] = ($urandom_range(99) < dens);
        endcase
      end
    end
  endtask

  // Reference: direct neighbourhood evaluation on the 2-D frame, border = 0.
  task automatic push_expected(input int d, input int w, input int h, input int k, input int mode);
    int r, cnt, xx, yy;
    bit res;
    r = k / 2;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        cnt = 0;
        for (int dy = -r; dy <= r; dy++) begin
          for (int dx = -r; dx <= r; dx++) begin
            xx = x + dx; yy = y + dy;
            if (xx >= 0 && xx < w && yy >= 0 && yy < h && pat[yy*w+xx]) cnt++;
          end
        end
        case (mode)
          0:       res = (cnt == k * k);
          1:       res = (cnt > 0);
          2:       res = (cnt > (k * k) / 2);
          default: res = pat[y*w+x];
        endcase
        if (d == 0) q0.push_back({res, (x == 0 && y == 0), (x == w - 1 && y == h - 1)});
        else        q1.push_back({res, (x == 0 && y == 0), (x == w - 1 && y == h - 1)});
      end
    end
  endtask

  task automatic send_frame(input int d, input int n, input int gap, input int stop_after,
                            input int sw_at, input logic [1:0] sw_mode);
    int i = 0;
    int idle = 0;
    while (i < n) begin
      @(negedge clk);
      if (stop_after >= 0 && out_cnt[d] >= stop_after) break;
      if (i == sw_at) begin
        if (d == 0) mode0 = sw_mode; else mode1 = sw_mode;
      end
      if ($urandom_range(99) < gap) begin
        set_in(d, 1'b0, 1'b0);
        idle++;
      end else begin
        set_in(d, 1'b1, pat[i]);
        if (get_rdy(d)) begin
          if (d == 0) acc_t[i] = $time;
          i++;
          idle = 0;
        end else begin
          idle++;
        end
      end
      if (idle > 400) begin
        checks++; errors++;
        $display("FAIL send_timeout dut=%0d index=%0d got in_ready=0 expected 1", d, i);
        break;
      end
    end
    @(negedge clk);
    set_in(d, 1'b0, 1'b0);
  endtask

  task automatic wait_done(input int d);
    int t = 0;
    while (!(qsize(d) == 0 && !get_busy(d))) begin
      if (t >= 800) begin
        checks++; errors++;
        $display("FAIL drain_timeout dut=%0d got pending=%0d expected 0", d, qsize(d));
        break;
      end
      @(negedge clk);
      t++;
    end
  endtask

  task automatic run_frame(input int d, input int w, input int h, input int k,
                           input logic [1:0] m, input int gap);
    int base;
    if (d == 0) mode0 = m; else mode1 = m;
    push_expected(d, w, h, k, int'(m));
    base = out_cnt[d];
    send_frame(d, w * h, gap, -1, -1, 2'd0);
    wait_done(d);
    chk("frame_output_count", out_cnt[d] - base, w * h);
  endtask

  initial begin
    int ones_base, lo_base, stop, base1;
    rst0 = 1'b1; rst1 = 1'b1;
    mode0 = 2'd0; mode1 = 2'd0;
    vld0 = 1'b0; px0 = 1'b0; vld1 = 1'b0; px1 = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs(0, "reset_state_dut0");
    check_idle_outputs(1, "reset_state_dut1");
    @(posedge clk); #1;
    rst0 = 1'b0; rst1 = 1'b0;

    gen_pat(W0, H0, 0, 0);
    ones_base = ones_cnt[0];
    run_frame(0, W0, H0, K0, 2'd0, 0);
    chk("erode_all_ones_count", ones_cnt[0] - ones_base, 24);

    gen_pat(W0, H0, 1, 0);
    ones_base = ones_cnt[0];
    run_frame(0, W0, H0, K0, 2'd1, 0);
    chk("dilate_single_count", ones_cnt[0] - ones_base, 9);

    gen_pat(W0, H0, 2, 0);
    run_frame(0, W0, H0, K0, 2'd2, 0);

    gen_pat(W0, H0, 3, 50);
    lo_base = lo_cnt0;
    run_frame(0, W0, H0, K0, 2'd3, 30);
    chk("bypass_flush_cycles", lo_cnt0 - lo_base, (K0 / 2) * W0 + K0 / 2);
    chk("bypass_first_out_latency", int'(sof_t0 - acc_t[(K0 / 2) * W0 + K0 / 2]), 10);

    for (int m = 0; m < 4; m++) begin
      gen_pat(W0, H0, 3, (m == 0) ? 85 : (m == 1) ? 10 : 50);
      run_frame(0, W0, H0, K0, 2'(m), 20);
    end

    // Two back-to-back K=5 frames; mode input changes part-way through frame 1.
    gen_pat(W1, H1, 3, 50);
    mode1 = 2'd2;
    push_expected(1, W1, H1, K1, 2);
    base1 = out_cnt[1];
    send_frame(1, W1 * H1, 0, -1, 40, 2'd1);
    gen_pat(W1, H1, 3, 10);
    push_expected(1, W1, H1, K1, 1);
    send_frame(1, W1 * H1, 0, -1, -1, 2'd0);
    wait_done(1);
    chk("b2b_output_count", out_cnt[1] - base1, 2 * W1 * H1);

    // Reset part-way through a frame, then a clean frame.
    gen_pat(W0, H0, 3, 50);
    mode0 = 2'd2;
    push_expected(0, W0, H0, K0, 2);
    stop = out_cnt[0] + 20;
    send_frame(0, W0 * H0, 0, stop, -1, 2'd0);
    chk("busy_mid_frame", int'(busy0), 1);
    @(posedge clk); #1;
    rst0 = 1'b1;
    q0.delete();
    #1;
    check_idle_outputs(0, "outputs_during_reset");
    repeat (3) @(negedge clk);
    check_idle_outputs(0, "outputs_held_in_reset");
    @(posedge clk); #1;
    rst0 = 1'b0;
    gen_pat(W0, H0, 3, 50);
    run_frame(0, W0, H0, K0, 2'd2, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got still running expected finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
